// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg: opcodes, width defaults and access-size decode for mem_stage |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mem_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_REG_DEF  = 5;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWU = 6'b100111;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Unlisted opcodes fall through to a full-word access.
  function automatic size_e op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      default:              return SIZE_WORD;
    endcase
  endfunction

  function automatic logic op_unsigned(input logic [5:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_memory: byte-enable sync-write array, async read + debug port,   |
// | synchronous clear. Revision: 1.0                                      |
// +----------------------------------------------------------------------+
module data_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [NB_DATA/8-1:0] byte_en,
  input  logic [NB_ADDR-1:0]   addr,
  input  logic [NB_DATA-1:0]   wr_data,
  output logic [NB_DATA-1:0]   rd_data,
  input  logic [NB_ADDR-1:0]   dbg_addr,
  output logic [NB_DATA-1:0]   dbg_data
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int DEPTH    = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];

  // Clear wins over any write presented in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < NB_BYTES; b++) begin
        if (byte_en[b]) begin
          mem[addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data  = mem[addr];
  assign dbg_data = mem[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage: MIPS MEM stage - sized loads/stores, branch resolve, MEM/WB|
// | register. Option macro: MEM_MISALIGN_CHECK_EN. Revision: 1.0          |
// +----------------------------------------------------------------------+
module mem_stage
  import mem_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_PC     = 32,
  parameter int NB_REG    = NB_REG_DEF,
  parameter int NB_OPCODE = 6,
  parameter int NB_ADDR   = 7
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_MEM_enable,
  input  logic                 i_MEM_reg_write,
  input  logic                 i_MEM_mem_to_reg,
  input  logic                 i_MEM_mem_read,
  input  logic                 i_MEM_mem_write,
  input  logic                 i_MEM_branch,
  input  logic                 i_MEM_zero,
  input  logic [NB_OPCODE-1:0] i_MEM_opcode,
  input  logic [NB_PC-1:0]     i_MEM_branch_address,
  input  logic [NB_DATA-1:0]   i_MEM_alu_result,
  input  logic [NB_DATA-1:0]   i_MEM_store_data,
  input  logic [NB_REG-1:0]    i_MEM_selected_reg,
  input  logic [NB_ADDR-1:0]   i_MEM_debug_addr,
  output logic                 o_MEM_pc_src,
  output logic [NB_PC-1:0]     o_MEM_branch_address,
  output logic                 o_MEM_reg_write,
  output logic                 o_MEM_mem_to_reg,
  output logic [NB_DATA-1:0]   o_MEM_read_data,
  output logic [NB_DATA-1:0]   o_MEM_alu_result,
  output logic [NB_REG-1:0]    o_MEM_selected_reg,
  output logic [NB_DATA-1:0]   o_MEM_debug_data,
  output logic                 o_MEM_misaligned
);

  localparam int NB_BYTES = NB_DATA / 8;

  logic [5:0]          op;
  logic [NB_ADDR-1:0]  word_addr;
  logic [1:0]          lane;
  size_e               size;
  logic                is_unsigned;
  logic                misaligned;
  logic                store_en;
  logic [NB_BYTES-1:0] byte_en;
  logic [NB_DATA-1:0]  wr_data;
  logic [NB_DATA-1:0]  mem_word;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;
  logic [NB_DATA-1:0]  load_data;

  assign op          = i_MEM_opcode[5:0];
  assign word_addr   = i_MEM_alu_result[NB_ADDR+1:2];
  assign lane        = i_MEM_alu_result[1:0];
  assign size        = op_size(op);
  assign is_unsigned = op_unsigned(op);

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (i_MEM_mem_read || i_MEM_mem_write) begin
      if (size == SIZE_HALF) begin
        misaligned = lane[0];
      end else if ((op == OP_LW) || (op == OP_LWU) || (op == OP_SW)) begin
        misaligned = (lane != 2'b00);
      end
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  // Store data is replicated across lanes so byte_en alone picks the target.
  always_comb begin
    byte_en = '1;
    wr_data = i_MEM_store_data;
    case (size)
      SIZE_BYTE: begin
        byte_en = NB_BYTES'(1) << lane;
        wr_data = {NB_BYTES{i_MEM_store_data[7:0]}};
      end
      SIZE_HALF: begin
        byte_en = NB_BYTES'(3) << {lane[1], 1'b0};
        wr_data = {(NB_BYTES/2){i_MEM_store_data[15:0]}};
      end
      default: begin
        byte_en = '1;
        wr_data = i_MEM_store_data;
      end
    endcase
  end

  assign store_en = i_MEM_mem_write & i_MEM_enable & ~misaligned;

  data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .clock    (i_clock),
    .reset    (i_reset),
    .wr_en    (store_en),
    .byte_en  (byte_en),
    .addr     (word_addr),
    .wr_data  (wr_data),
    .rd_data  (mem_word),
    .dbg_addr (i_MEM_debug_addr),
    .dbg_data (o_MEM_debug_data)
  );

  assign lane_byte = mem_word[{lane, 3'b000} +: 8];
  assign lane_half = mem_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    if (i_MEM_mem_read && !misaligned) begin
      case (size)
        SIZE_BYTE: load_data = is_unsigned ? {{(NB_DATA-8){1'b0}}, lane_byte}
                                           : {{(NB_DATA-8){lane_byte[7]}}, lane_byte};
        SIZE_HALF: load_data = is_unsigned ? {{(NB_DATA-16){1'b0}}, lane_half}
                                           : {{(NB_DATA-16){lane_half[15]}}, lane_half};
        default:   load_data = mem_word;
      endcase
    end
  end

  assign o_MEM_pc_src         = i_MEM_branch & i_MEM_zero;
  assign o_MEM_branch_address = i_MEM_branch_address;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_MEM_reg_write    <= 1'b0;
      o_MEM_mem_to_reg   <= 1'b0;
      o_MEM_read_data    <= '0;
      o_MEM_alu_result   <= '0;
      o_MEM_selected_reg <= '0;
      o_MEM_misaligned   <= 1'b0;
    end else if (i_MEM_enable) begin
      o_MEM_reg_write    <= i_MEM_reg_write;
      o_MEM_mem_to_reg   <= i_MEM_mem_to_reg;
      o_MEM_read_data    <= load_data;
      o_MEM_alu_result   <= i_MEM_alu_result;
      o_MEM_selected_reg <= i_MEM_selected_reg;
      o_MEM_misaligned   <= misaligned;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stage: randomized scoreboard bench for mem_stage               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset, enable, reg_write, mem_to_reg, mem_read, mem_write, branch, zero;
  logic [5:0]  opcode;
  logic [31:0] branch_address, alu_result, store_data;
  logic [4:0]  selected_reg;
  logic [6:0]  debug_addr;
  logic        pc_src, o_reg_write, o_mem_to_reg, misaligned;
  logic [31:0] o_branch_address, read_data, o_alu_result, debug_data;
  logic [4:0]  o_selected_reg;

  always #5 clock = ~clock;

  mem_stage dut (
    .i_clock              (clock),
    .i_reset              (reset),
    .i_MEM_enable         (enable),
    .i_MEM_reg_write      (reg_write),
    .i_MEM_mem_to_reg     (mem_to_reg),
    .i_MEM_mem_read       (mem_read),
    .i_MEM_mem_write      (mem_write),
    .i_MEM_branch         (branch),
    .i_MEM_zero           (zero),
    .i_MEM_opcode         (opcode),
    .i_MEM_branch_address (branch_address),
    .i_MEM_alu_result     (alu_result),
    .i_MEM_store_data     (store_data),
    .i_MEM_selected_reg   (selected_reg),
    .i_MEM_debug_addr     (debug_addr),
    .o_MEM_pc_src         (pc_src),
    .o_MEM_branch_address (o_branch_address),
    .o_MEM_reg_write      (o_reg_write),
    .o_MEM_mem_to_reg     (o_mem_to_reg),
    .o_MEM_read_data      (read_data),
    .o_MEM_alu_result     (o_alu_result),
    .o_MEM_selected_reg   (o_selected_reg),
    .o_MEM_debug_data     (debug_data),
    .o_MEM_misaligned     (misaligned)
  );

  typedef struct {
    logic rst, en, rw, m2r, rd, wr, br, z;
    logic [5:0]  op;
    logic [31:0] bra, alu, sd;
    logic [4:0]  sel;
    logic [6:0]  dbg;
  } stim_t;

  typedef struct {
    logic        rw, m2r, mis, pc;
    logic [31:0] rd, alu, bra, dbg;
    logic [4:0]  sel;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        st;
  logic [7:0]  ref_mem [512];
  int          total = 0;
  int          bad   = 0;

  logic [5:0] load_ops  [7] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100,
                                6'b100101, 6'b100111, 6'b000000};
  logic [5:0] store_ops [4] = '{6'b101000, 6'b101001, 6'b101011, 6'b000000};
  logic [5:0] both_ops  [3] = '{6'b101011, 6'b100011, 6'b001000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int nbytes(input logic [5:0] op);
    if (op == 6'b100000 || op == 6'b100100 || op == 6'b101000) return 1;
    if (op == 6'b100001 || op == 6'b100101 || op == 6'b101001) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] word_at(input int base);
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  // Reference: memory is a flat little-endian byte array of 512 bytes.
  task automatic step(input stim_t s);
    int          a, n, base;
    logic        mis;
    logic [31:0] val;
    exp_t        e;
    @(negedge clock);
    reset = s.rst; enable = s.en; reg_write = s.rw; mem_to_reg = s.m2r;
    mem_read = s.rd; mem_write = s.wr; branch = s.br; zero = s.z;
    opcode = s.op; branch_address = s.bra; alu_result = s.alu;
    store_data = s.sd; selected_reg = s.sel; debug_addr = s.dbg;

    a    = int'(s.alu % 512);
    n    = nbytes(s.op);
    base = (n == 1) ? a : (n == 2) ? (a / 4) * 4 + ((a % 4) >= 2 ? 2 : 0) : (a / 4) * 4;
    mis  = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    if (s.rd || s.wr) begin
      if (n == 2 && (a % 2) == 1) mis = 1'b1;
      if ((s.op == 6'b100011 || s.op == 6'b100111 || s.op == 6'b101011) && (a % 4) != 0)
        mis = 1'b1;
    end
`endif
    if (s.rst) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
      st = '{rw: 1'b0, m2r: 1'b0, mis: 1'b0, pc: 1'b0, rd: 32'h0, alu: 32'h0,
             bra: 32'h0, dbg: 32'h0, sel: 5'h0};
    end else if (s.en) begin
      val = 32'h0;
      for (int k = 0; k < n; k++) val = val + (32'(ref_mem[base+k]) << (8 * k));
      if (n == 1 && s.op == 6'b100000 && val >= 32'h80)   val = val - 32'h100;
      if (n == 2 && s.op == 6'b100001 && val >= 32'h8000) val = val - 32'h10000;
      st.rd  = (s.rd && !mis) ? val : 32'h0;
      st.rw  = s.rw;
      st.m2r = s.m2r;
      st.alu = s.alu;
      st.sel = s.sel;
      st.mis = mis;
      if (s.wr && !mis)
        for (int k = 0; k < n; k++) ref_mem[base+k] = 8'((s.sd >> (8 * k)) & 32'hFF);
    end
    e     = st;
    e.pc  = s.br & s.z;
    e.bra = s.bra;
    e.dbg = word_at(int'(s.dbg) * 4);
    sb_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, en: 1'b1, rw: 1'b0, m2r: 1'b0, rd: 1'b0, wr: 1'b0, br: 1'b0,
          z: 1'b0, op: 6'b0, bra: 32'h0, alu: 32'h0, sd: 32'h0, sel: 5'h0, dbg: 7'h0};
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("reg_write",    32'(o_reg_write),    32'(e.rw));
        check("mem_to_reg",   32'(o_mem_to_reg),   32'(e.m2r));
        check("read_data",    read_data,           e.rd);
        check("alu_result",   o_alu_result,        e.alu);
        check("selected_reg", 32'(o_selected_reg), 32'(e.sel));
        check("misaligned",   32'(misaligned),     32'(e.mis));
        check("pc_src",       32'(pc_src),         32'(e.pc));
        check("branch_addr",  o_branch_address,    e.bra);
        check("debug_data",   debug_data,          e.dbg);
      end
    end
  end

  task automatic after_edge();
    @(posedge clock);
    #2;
  endtask

  initial begin : stimulus
    stim_t s;
    int    r;
    reset = 1'b1; enable = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0; zero = 1'b0;
    opcode = 6'b0; branch_address = '0; alu_result = '0; store_data = '0;
    selected_reg = '0; debug_addr = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    st = '{rw: 1'b0, m2r: 1'b0, mis: 1'b0, pc: 1'b0, rd: 32'h0, alu: 32'h0,
           bra: 32'h0, dbg: 32'h0, sel: 5'h0};

    s = idle(); s.rst = 1'b1; step(s); step(s);
    after_edge();
    check("reset_read_data", read_data, 32'h0);

    s = idle(); s.wr = 1'b1; s.op = 6'b101011; s.alu = 32'h8; s.sd = 32'hDEADBEEF; step(s);
    s = idle(); s.rd = 1'b1; s.op = 6'b100011; s.alu = 32'h8; s.dbg = 7'd2; step(s);
    after_edge();
    check("lw_deadbeef", read_data, 32'hDEADBEEF);
    check("dbg_deadbeef", debug_data, 32'hDEADBEEF);

    s = idle(); s.wr = 1'b1; s.op = 6'b101000; s.alu = 32'h9; s.sd = 32'h00000080; step(s);
    s = idle(); s.rd = 1'b1; s.op = 6'b100000; s.alu = 32'h9; step(s);
    after_edge(); check("lb_sign", read_data, 32'hFFFFFF80);
    s.op = 6'b100100; step(s);
    after_edge(); check("lbu_zero", read_data, 32'h00000080);
    s.op = 6'b100011; s.alu = 32'h8; step(s);
    after_edge(); check("lw_after_sb", read_data, 32'hDEAD80EF);

    s = idle(); s.wr = 1'b1; s.op = 6'b101001; s.alu = 32'hA; s.sd = 32'h00008001; step(s);
    s = idle(); s.rd = 1'b1; s.op = 6'b100001; s.alu = 32'hA; step(s);
    after_edge(); check("lh_sign", read_data, 32'hFFFF8001);
    s.alu = 32'hB; step(s);
    after_edge();
`ifdef MEM_MISALIGN_CHECK_EN
    check("lh_misaligned_data", read_data, 32'h0);
    check("lh_misaligned_flag", 32'(misaligned), 32'h1);
`else
    check("lh_truncated_data", read_data, 32'hFFFF8001);
    check("lh_truncated_flag", 32'(misaligned), 32'h0);
`endif
    s.op = 6'b100101; s.alu = 32'hA; step(s);
    after_edge(); check("lhu_zero", read_data, 32'h00008001);

    s = idle(); s.en = 1'b0; s.wr = 1'b1; s.op = 6'b101011; s.alu = 32'h0;
    s.sd = 32'h12345678; s.rw = 1'b1; s.sel = 5'd9; step(s);
    after_edge();
    check("stall_no_write", debug_data, 32'h0);
    check("stall_hold_data", read_data, 32'h00008001);
    check("stall_hold_alu", o_alu_result, 32'hA);
    s.en = 1'b1; step(s);
    after_edge(); check("release_write", debug_data, 32'h12345678);

    s = idle(); s.br = 1'b1; s.z = 1'b1; s.bra = 32'h40; step(s);
    #1;
    check("pc_src_taken", 32'(pc_src), 32'h1);
    check("branch_addr_pass", o_branch_address, 32'h40);
    s.z = 1'b0; step(s);
    #1;
    check("pc_src_not_taken", 32'(pc_src), 32'h0);

    s = idle(); s.wr = 1'b1; s.op = 6'b101011; s.alu = 32'h4; s.sd = 32'hA5A5A5A5;
    s.rw = 1'b1; s.m2r = 1'b1; s.sel = 5'd7; s.dbg = 7'd1; step(s);
    after_edge(); check("pre_reset_word1", debug_data, 32'hA5A5A5A5);
    s.rst = 1'b1; s.sd = 32'h11111111; step(s);
    after_edge();
    check("reset_store_dropped", debug_data, 32'h0);
    check("reset_alu", o_alu_result, 32'h0);
    check("reset_reg_write", 32'(o_reg_write), 32'h0);
    check("reset_sel", 32'(o_selected_reg), 32'h0);

    for (int i = 0; i < 600; i++) begin
      s     = idle();
      s.rst = ($urandom % 64) == 0;
      s.en  = ($urandom % 8) != 0;
      s.rw  = 1'($urandom);
      s.m2r = 1'($urandom);
      s.br  = 1'($urandom);
      s.z   = 1'($urandom);
      s.bra = $urandom;
      s.sd  = $urandom;
      s.sel = 5'($urandom);
      s.dbg = 7'($urandom_range(0, 15));
      s.alu = (($urandom % 4) == 0) ? $urandom : 32'($urandom_range(0, 63));
      r = $urandom % 4;
      s.rd = r[0];
      s.wr = r[1];
      case (r)
        1:       s.op = load_ops[$urandom % 7];
        2:       s.op = store_ops[$urandom % 4];
        3:       s.op = both_ops[$urandom % 3];
        default: s.op = 6'($urandom);
      endcase
      step(s);
    end

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clock);
    #3;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0 pending entries", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
